alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the processor's combinational ALU. Operands enter through a valid/ready port, and results are held in an output register until the consumer takes them. The block adds logic and shift ops to add/sub and produces corrected flags. With `ALU_MUL_EN`, it also runs an iterative signed multiply over several cycles. It sits between the decode/issue stage and writeback in the execute stage.

## Interface
- `WIDTH`, default 32: operand and result width (≥ 4, power of two).
- `SHW` (localparam) = `$clog2(WIDTH)`: shift-amount width.
- `clock` in 1: single clock, all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operand bundle is valid.
- `in_ready` out 1: block accepts a bundle this cycle.
- `data_operandA`, `data_operandB` in WIDTH: operands, two's complement.
- `ctrl_ALUopcode` in 5: operation select.
- `ctrl_shiftamt` in SHW: shift distance.
- `out_valid` out 1: result register holds an unconsumed result.
- `out_ready` in 1: consumer takes the result this cycle.
- `data_result` out WIDTH: registered result.
- `isNotEqual`, `isLessThan`, `overflow` out 1: registered flags.

## Operation
- Opcodes:
  - 00000 ADD: A+B.
  - 00001 SUB: A−B.
  - 00010 AND.
  - 00011 OR.
  - 00100 SLL: A << shiftamt.
  - 00101 SRA: A >>> shiftamt, sign-filled.
  - 00110 MUL: only with `ALU_MUL_EN`.
  - Any other code: result 0, all flags 0, normal handshake.
- Arithmetic wraps modulo 2^WIDTH.
- `overflow`:
  - ADD/SUB: set on signed overflow (operand signs agree, result sign differs, with B inverted for SUB).
  - MUL: set when the full 2·WIDTH signed product does not fit in WIDTH bits.
  - All other ops: 0.
- `isNotEqual` = (A != B) for every defined opcode.
- `isLessThan` = signed A < B, computed as the true sign of A−B (sum sign XOR overflow). It stays correct under overflow and is valid for every defined opcode.
- Accept: an accept occurs when `in_valid && in_ready`.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready), so accept and drain can happen in the same cycle.
- FSM states and transitions:
  - IDLE:
    - Single-cycle op accepted: load the output register, set `out_valid`, stay in IDLE.
    - MUL accepted: latch |A| and |B| and the product sign, clear the accumulator, go to MUL.
  - MUL:
    - Each cycle performs one radix-2 shift-add step, using a counter from 0 to WIDTH−1.
    - After step WIDTH−1, go to FIX.
  - FIX:
    - Negate the 2·WIDTH product if the sign is set.
    - Load the low WIDTH bits and the overflow flag.
    - Set `out_valid` and go to IDLE.
    - Output-register space is guaranteed because `in_ready` required it at accept.
- Output register behaviour:
  - Holds its contents while `out_valid && !out_ready`.
  - `out_valid` clears on drain unless a new result loads on the same edge.
- The most-negative operand in MUL: its magnitude (2^(WIDTH−1)) is held as unsigned WIDTH bits, giving the correct product and overflow.
- Reset:
  - `data_result` = 0, all flags = 0, `out_valid` = 0.
  - FSM goes to IDLE and the counter to 0. `in_ready` reads 1 in the first cycle after reset deasserts.
  - Reset during MUL/FIX aborts the multiply; no result is produced.

## Timing
- Single-cycle ops: accept at edge t gives `out_valid` = 1 after edge t, so latency is 1.
- Back-to-back throughput is one op per cycle while `out_ready` = 1.
- MUL: accept at edge t.
  - Steps occur on edges t+1 … t+WIDTH; FIX is on edge t+WIDTH+1.
  - `out_valid` is high after edge t+WIDTH+1, so latency is WIDTH+1 (33 at WIDTH = 32).
  - `in_ready` = 0 throughout MUL and FIX.
- No combinational path from `in_valid` to `out_valid` or from operands to outputs. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `ALU_MUL_EN` defined:
  - Opcode 00110 performs the iterative MUL.
  - The MUL/FIX states and counter are built.
- `ALU_MUL_EN` undefined:
  - 00110 is treated as an undefined opcode (result 0, flags 0, latency 1).
  - The FSM reduces to IDLE only and no multiply logic is synthesised.

## Test plan
- Reset asserted for 2 cycles, then released → all outputs 0, `in_ready` = 1, `out_valid` = 0.
- ADD with A=0x7FFFFFFF, B=1 → result 0x80000000, `overflow` = 1, `isLessThan` = 0, `isNotEqual` = 1, `out_valid` one cycle after accept.
- SUB with A=0x80000000, B=1 → result 0x7FFFFFFF, `overflow` = 1, `isLessThan` = 1. SRA of 0x80000000 by 4 → 0xF8000000.
- Backpressure:
  - Setup: accept ADD 3+4, hold `out_ready` = 0 for 3 cycles while `in_valid` = 1.
  - Expect: `in_ready` = 0, result 7 held stable.
  - Then raise `out_ready`: the drain and the next accept occur on the same edge.
- MUL (`ALU_MUL_EN`): −3 × 7 → 0xFFFFFFEB, `overflow` = 0, `out_valid` 33 cycles after accept. 0x00010000 × 0x00010000 → 0, `overflow` = 1.
- Reset asserted 10 cycles into a MUL → no `out_valid`, block back to IDLE with `in_ready` = 1 after reset releases. Without `ALU_MUL_EN`, opcode 00110 → result 0, flags 0, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: add/sub/logic/shift in one cycle, registered result and flags.
// Optional iterative signed multiply (opcode 00110) built only when ALU_MUL_EN is defined.
module alu_seq #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow
);

`ifdef ALU_MUL_EN
    localparam int unsigned W2 = 2 * WIDTH;
    typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
`else
    typedef enum logic [0:0] {IDLE} state_t;
`endif

    state_t           state_q, state_d;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] sum_c, diff_c, alu_res_c;
    logic             add_ovf_c, sub_ovf_c, alu_ovf_c, defined_c, lt_c;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; less-than uses the true sign of A-B so it survives overflow
    always_comb begin
        sum_c     = data_operandA + data_operandB;
        diff_c    = data_operandA - data_operandB;
        add_ovf_c = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                    (sum_c[WIDTH-1] != data_operandA[WIDTH-1]);
        sub_ovf_c = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                    (diff_c[WIDTH-1] != data_operandA[WIDTH-1]);
        lt_c      = diff_c[WIDTH-1] ^ sub_ovf_c;
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        defined_c = 1'b1;
        case (ctrl_ALUopcode)
            5'b00000: begin alu_res_c = sum_c;  alu_ovf_c = add_ovf_c; end
            5'b00001: begin alu_res_c = diff_c; alu_ovf_c = sub_ovf_c; end
            5'b00010: alu_res_c = data_operandA & data_operandB;
            5'b00011: alu_res_c = data_operandA | data_operandB;
            5'b00100: alu_res_c = data_operandA << ctrl_shiftamt;
            5'b00101: alu_res_c = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
            default:  defined_c = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [W2-1:0]    acc_q, ma_q, prod_c;
    logic [WIDTH-1:0] mb_q, abs_a_c, abs_b_c;
    logic [SHW-1:0]   cnt_q;
    logic             sign_q, mul_ne_q, mul_lt_q, mul_ovf_c;

    assign is_mul    = (ctrl_ALUopcode == 5'b00110);
    assign abs_a_c   = data_operandA[WIDTH-1] ? (WIDTH'(0) - data_operandA) : data_operandA;
    assign abs_b_c   = data_operandB[WIDTH-1] ? (WIDTH'(0) - data_operandB) : data_operandB;
    assign prod_c    = sign_q ? (W2'(0) - acc_q) : acc_q;
    assign mul_ovf_c = prod_c[W2-1:WIDTH] != {WIDTH{prod_c[WIDTH-1]}};

    // Radix-2 shift-add on unsigned magnitudes; sign is reapplied in FIX
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            mul_ne_q <= 1'b0;
            mul_lt_q <= 1'b0;
        end else if (accept && is_mul) begin
            acc_q    <= '0;
            ma_q     <= {{WIDTH{1'b0}}, abs_a_c};
            mb_q     <= abs_b_c;
            cnt_q    <= '0;
            sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            mul_ne_q <= data_operandA != data_operandB;
            mul_lt_q <= lt_c;
        end else if (state_q == MUL) begin
            if (mb_q[0]) begin
                acc_q <= acc_q + ma_q;
            end
            ma_q  <= ma_q << 1;
            mb_q  <= mb_q >> 1;
            cnt_q <= cnt_q + SHW'(1);
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_mul) state_d = state_t'(1);
`ifdef ALU_MUL_EN
            MUL:  if (cnt_q == SHW'(WIDTH - 1)) state_d = FIX;
            FIX:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output register: a same-edge load wins over the drain
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !is_mul) begin
                out_valid   <= 1'b1;
                data_result <= alu_res_c;
                overflow    <= alu_ovf_c;
                isNotEqual  <= defined_c && (data_operandA != data_operandB);
                isLessThan  <= defined_c && lt_c;
            end
`ifdef ALU_MUL_EN
            if (state_q == FIX) begin
                out_valid   <= 1'b1;
                data_result <= prod_c[WIDTH-1:0];
                overflow    <= mul_ovf_c;
                isNotEqual  <= mul_ne_q;
                isLessThan  <= mul_lt_q;
            end
`endif
        end
    end

endmodule
